md_ctrl: RTL and testbench

Multiply/divide sequencer for the five-stage pipeline. It owns the HI/LO registers and times multi-cycle MULT/MULTU/DIV/DIVU operations issued from the E stage. It also raises the D-stage stall request that keeps any HI/LO instruction out of E while an operation is pending. Its stall output is ORed with the existing hazard stall at the pipeline top.

---
 rtl/md_ctrl.sv | 129 ++++++++++++
 tb/tb_md_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// HI/LO register owner and multi-cycle MULT/DIV sequencer for the E stage.
// Results are computed at the start edge and committed when the busy countdown expires.
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        is_start_op, start, div_zero;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_rs, abs_rt, q_mag, r_mag, q_s, r_s, q_u, r_u;

    always_comb begin
        is_start_op = (E_md_op >= 3'd1) && (E_md_op <= 3'd4);
        start       = is_start_op && (state_q == StIdle);
        div_zero    = (E_rt == 32'd0);

        // Low 64 bits of a product of sign-extended operands equal the signed product.
        prod_s = {{32{E_rs[31]}}, E_rs} * {{32{E_rt[31]}}, E_rt};
        prod_u = {32'd0, E_rs} * {32'd0, E_rt};

        // Signed divide via magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0.
        abs_rs = E_rs[31] ? (~E_rs + 32'd1) : E_rs;
        abs_rt = E_rt[31] ? (~E_rt + 32'd1) : E_rt;
        q_mag  = div_zero ? 32'd0 : abs_rs / abs_rt;
        r_mag  = div_zero ? 32'd0 : abs_rs % abs_rt;
        q_s    = (E_rs[31] ^ E_rt[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s    = E_rs[31] ? (~r_mag + 32'd1) : r_mag;
        q_u    = div_zero ? 32'd0 : E_rs / E_rt;
        r_u    = div_zero ? 32'd0 : E_rs % E_rt;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = (E_md_op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
                    unique case (E_md_op)
                        3'd1: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                        end
                        3'd2: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                        end
                        3'd3: begin
                            pend_hi_d = r_s;
                            pend_lo_d = q_s;
                            pend_wr_d = !div_zero;
                        end
                        default: begin
                            pend_hi_d = r_u;
                            pend_lo_d = q_u;
                            pend_wr_d = !div_zero;
                        end
                    endcase
                end else if (E_md_op == 3'd5) begin
                    hi_d = E_rs;
                end else if (E_md_op == 3'd6) begin
                    lo_d = E_rs;
                end
            end
            StRun: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = StIdle;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign stall_md = D_md & (busy | is_start_op);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl: latency, results, stall and async reset.
module tb_md_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  E_md_op;
    logic [31:0] E_rs, E_rt;
    logic        D_md;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_ctrl #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .E_md_op (E_md_op),
        .E_rs    (E_rs),
        .E_rt    (E_rt),
        .D_md    (D_md),
        .busy    (busy),
        .stall_md(stall_md),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        E_md_op = op;
        E_rs    = rs;
        E_rt    = rt;
        tick();
        E_md_op = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0; E_md_op = 3'd0; E_rs = '0; E_rt = '0; D_md = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %h want 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_lo got %h want 0", lo); end
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL rst_stall got %h want 0", stall_md); end
        D_md = 1'b1; E_md_op = 3'd1; #1;
        checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL rst_stall_start got %h want 1", stall_md); end
        E_md_op = 3'd0; #1;
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL rst_stall_idle got %h want 0", stall_md); end
        D_md = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < int'(MC); i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy[%0d] got %h want 1", i, busy); end
            checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mult_early_hi[%0d] got %h want 0", i, hi); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_done got %h want 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", lo); end
    endtask

    // Stray ops while busy must be ignored without disturbing the countdown.
    task automatic test_multu_ignored_ops();
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < int'(MC); i++) begin
            E_md_op = (i == 1) ? 3'd5 : (i == 2) ? 3'd3 : 3'd0;
            E_rs = 32'hDEAD_BEEF; E_rt = 32'd1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy[%0d] got %h want 1", i, busy); end
            tick();
        end
        E_md_op = 3'd0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_done got %h want 0", busy); end
        checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got %h want 00000001", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", lo); end
    endtask

    task automatic test_back_to_back();
        issue(3'd4, 32'd100, 32'd7);
        for (int i = 0; i < int'(DC); i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy[%0d] got %h want 1", i, busy); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_done got %h want 0", busy); end
        checks++; if (lo !== 32'h0000_000E) begin errors++; $display("FAIL divu_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL divu_hi got %h want 00000002", hi); end
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < int'(DC); i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got %h want 1", i, busy); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done got %h want 0", busy); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    endtask

    task automatic test_div_zero();
        issue(3'd5, 32'h1234_5678, 32'd0);
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got %h want 12345678", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %h want 0", busy); end
        issue(3'd6, 32'h9ABC_DEF0, 32'd0);
        checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo got %h want 9abcdef0", lo); end
        issue(3'd3, 32'd5, 32'd0);
        for (int i = 0; i < int'(DC); i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dz_busy[%0d] got %h want 1", i, busy); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_done got %h want 0", busy); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL dz_hi got %h want 12345678", hi); end
        checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL dz_lo got %h want 9abcdef0", lo); end
    endtask

    task automatic test_div_overflow();
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < int'(DC); i++) tick();
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL ovf_hi got %h want 00000000", hi); end
    endtask

    task automatic test_stall();
        D_md = 1'b1; E_md_op = 3'd1; E_rs = 32'd3; E_rt = 32'd4;
        #1;
        checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_start got %h want 1", stall_md); end
        tick();
        E_md_op = 3'd0;
        for (int i = 0; i < int'(MC); i++) begin
            checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d] got %h want 1", i, stall_md); end
            tick();
        end
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL stall_after got %h want 0", stall_md); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL stall_lo got %h want 0000000c", lo); end
        D_md = 1'b0; E_md_op = 3'd1;
        #1;
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL nostall_start got %h want 0", stall_md); end
        tick();
        E_md_op = 3'd0;
        for (int i = 0; i <= int'(MC); i++) begin
            checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL nostall[%0d] got %h want 0", i, stall_md); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        issue(3'd5, 32'h0000_0055, 32'd0);
        issue(3'd3, 32'd1000, 32'd3);
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %h want 1", busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %h want 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mid_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL mid_lo got %h want 0", lo); end
        @(negedge clk);
        reset = 1'b1;
        D_md = 1'b1;
        for (int i = 0; i < int'(DC) + 2; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_md !== 1'b0) begin
                errors++;
                $display("FAIL post_rst[%0d] got busy=%h hi=%h lo=%h stall=%h want 0/0/0/0",
                         i, busy, hi, lo, stall_md);
            end
        end
        D_md = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_ignored_ops();
        test_back_to_back();
        test_div_zero();
        test_div_overflow();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
